// File: rtl/instr_defs.sv
// Shared widths, queue entry type and helpers for the id0 instruction aligner.
package instr_defs;

  localparam int DataWidth    = 32;
  localparam int RegAddrWidth = 5;
  localparam int HwQueueDepth = 3;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;
  typedef logic [31:1]             pc_t;

  typedef struct packed {
    logic [15:0] data;
    pc_t         pc;
    logic        br;
    logic        br_taken;
  } hw_entry_t;

  // A halfword starts a 32-bit instruction when its two low bits are both set.
  function automatic logic is_32bit(input logic [15:0] hw);
    return hw[1:0] == 2'b11;
  endfunction

endpackage

// File: rtl/id0_rd_sel.sv
// Destination register extraction for 32-bit and RVC instructions.
module id0_rd_sel
  import instr_defs::*;
(
  input  logic [15:0] hw,
  input  logic        compressed,
  output reg_addr_t   rd
);

  // Compressed formats place rd in quadrant-specific fields or imply x0/x1.
  always_comb begin
    rd = hw[11:7];
    if (compressed) begin
      case (hw[1:0])
        2'b00: rd = {2'b01, hw[4:2]};
        2'b01: begin
          case (hw[15:13])
            3'b001:                 rd = 5'd1;
            3'b101, 3'b110, 3'b111: rd = 5'd0;
            3'b100:                 rd = {2'b01, hw[9:7]};
            default:                rd = hw[11:7];
          endcase
        end
        2'b10: begin
          if (hw[15:13] == 3'b100 && hw[12] && hw[11:7] != 5'd0 && hw[6:2] == 5'd0) begin
            rd = 5'd1;
          end else begin
            rd = hw[11:7];
          end
        end
        default: rd = hw[11:7];
      endcase
    end else begin
      rd = hw[11:7];
    end
  end

endmodule

// File: rtl/id0.sv
// id0: fetch-word to instruction aligner feeding decode-1.
// RVC_SUPPORT_EN enables the 3-entry halfword queue; otherwise a single word register is used.
module id0
  import instr_defs::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 fetch_valid,
  output logic                 fetch_ready,
  input  logic [DataWidth-1:0] fetch_data,
  input  logic [31:1]          fetch_pc,
  input  logic [1:0]           fetch_br,
  input  logic [1:0]           fetch_br_taken,
  output logic                 valid_d1,
  input  logic                 ready_d1,
  output logic [DataWidth-1:0] instr_d1,
  output logic [31:1]          pc_d1,
  output logic                 compressed_d1,
  output logic                 br_d1,
  output logic                 br_taken_d1,
  output reg_addr_t            rd_addr_d1
);

  logic                 load;
  logic                 head_valid;
  logic [DataWidth-1:0] head_instr;
  pc_t                  head_pc;
  logic                 head_c;
  logic                 head_br;
  logic                 head_tk;
  reg_addr_t            head_rd;

  assign load = !valid_d1 || ready_d1;

  id0_rd_sel u_rd_sel (
    .hw         (head_instr[15:0]),
    .compressed (head_c),
    .rd         (head_rd)
  );

`ifdef RVC_SUPPORT_EN
  hw_entry_t q  [HwQueueDepth];
  hw_entry_t nq [HwQueueDepth];
  hw_entry_t in0;
  hw_entry_t in1;
  logic [1:0] hw_cnt;
  logic [1:0] n_cnt;
  logic [1:0] consumed;
  logic [1:0] remain;
  logic [1:0] kept;
  logic       issue;
  logic       accept;
  int         src;

  assign in0 = {fetch_data[15:0],  fetch_pc[31:2], 1'b0, fetch_br[0], fetch_br_taken[0]};
  assign in1 = {fetch_data[31:16], fetch_pc[31:2], 1'b1, fetch_br[1], fetch_br_taken[1]};

  // Head decode, issue decision and fetch backpressure.
  always_comb begin
    head_c     = !is_32bit(q[0].data);
    head_valid = (hw_cnt != 2'd0) && (head_c || hw_cnt >= 2'd2);
    head_instr = head_c ? {16'h0000, q[0].data} : {q[1].data, q[0].data};
    head_pc    = q[0].pc;
    head_br    = q[0].br;
    head_tk    = q[0].br_taken;
    issue      = load && head_valid;
    consumed   = !issue ? 2'd0 : (head_c ? 2'd1 : 2'd2);
    remain     = hw_cnt - consumed;
    kept       = (issue && head_tk) ? 2'd0 : remain;
    fetch_ready = !rst && !flush && (remain <= 2'd1);
    accept     = fetch_valid && fetch_ready;
  end

  // Shift out consumed halfwords, then append the accepted word's halfwords.
  always_comb begin
    nq  = q;
    src = 0;
    for (int i = 0; i < HwQueueDepth; i++) begin
      src = i + int'(consumed);
      if (i < int'(kept) && src < HwQueueDepth) begin
        nq[i] = q[src];
      end else if (accept && i == int'(kept)) begin
        nq[i] = fetch_pc[1] ? in1 : in0;
      end else if (accept && !fetch_pc[1] && i == int'(kept) + 1) begin
        nq[i] = in1;
      end else begin
        nq[i] = q[i];
      end
    end
    n_cnt = kept + (accept ? (fetch_pc[1] ? 2'd1 : 2'd2) : 2'd0);
  end

  // Halfword queue state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hw_cnt <= 2'd0;
    end else if (flush) begin
      hw_cnt <= 2'd0;
    end else begin
      hw_cnt <= n_cnt;
      q      <= nq;
    end
  end
`else
  logic                 w_valid;
  logic [DataWidth-1:0] w_data;
  pc_t                  w_pc;
  logic                 w_br;
  logic                 w_tk;
  logic                 issue;

  // Single word register is the head; every instruction is 32-bit.
  always_comb begin
    head_valid  = w_valid;
    head_instr  = w_data;
    head_pc     = w_pc;
    head_c      = 1'b0;
    head_br     = w_br;
    head_tk     = w_tk;
    issue       = load && w_valid;
    fetch_ready = !rst && !flush && (!w_valid || issue);
  end

  // Word register; tags come from the first valid halfword of the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_valid <= 1'b0;
    end else if (flush) begin
      w_valid <= 1'b0;
    end else if (fetch_valid && fetch_ready) begin
      w_valid <= 1'b1;
      w_data  <= fetch_data;
      w_pc    <= fetch_pc;
      w_br    <= fetch_br[fetch_pc[1]];
      w_tk    <= fetch_br_taken[fetch_pc[1]];
    end else if (issue) begin
      w_valid <= 1'b0;
    end
  end
`endif

  // Decode-1 output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_d1      <= 1'b0;
      instr_d1      <= '0;
      pc_d1         <= '0;
      compressed_d1 <= 1'b0;
      br_d1         <= 1'b0;
      br_taken_d1   <= 1'b0;
      rd_addr_d1    <= '0;
    end else if (flush) begin
      valid_d1 <= 1'b0;
    end else if (load) begin
      valid_d1      <= head_valid;
      instr_d1      <= head_instr;
      pc_d1         <= head_pc;
      compressed_d1 <= head_c;
      br_d1         <= head_br;
      br_taken_d1   <= head_tk;
      rd_addr_d1    <= head_rd;
    end
  end

endmodule

// File: tb/tb_id0.sv
// Self-checking bench for id0; follows RVC_SUPPORT_EN to pick the expected behaviour.
module tb_id0;
  import instr_defs::*;

  logic        clk = 1'b0;
  logic        rst, flush, fetch_valid, fetch_ready, valid_d1, ready_d1;
  logic [31:0] fetch_data, instr_d1;
  logic [31:1] fetch_pc, pc_d1;
  logic [1:0]  fetch_br, fetch_br_taken;
  logic        compressed_d1, br_d1, br_taken_d1;
  reg_addr_t   rd_addr_d1;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] instr; logic [31:1] pc; logic c; logic br; logic tk; logic [4:0] rd; } exp_t;
  typedef struct { logic [15:0] d; logic [31:1] pc; logic br; logic tk; } hw_t;
  exp_t expq[$];
  hw_t  hq[$];

  always #5 clk = ~clk;

  id0 dut (
    .clk(clk), .rst(rst), .flush(flush), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .fetch_pc(fetch_pc), .fetch_br(fetch_br), .fetch_br_taken(fetch_br_taken),
    .valid_d1(valid_d1), .ready_d1(ready_d1), .instr_d1(instr_d1), .pc_d1(pc_d1),
    .compressed_d1(compressed_d1), .br_d1(br_d1), .br_taken_d1(br_taken_d1), .rd_addr_d1(rd_addr_d1)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Destination register as written in the ISA rules.
  function automatic logic [4:0] ref_rd(input logic [31:0] ins, input logic c);
    logic [2:0] f3;
    f3 = ins[15:13];
    if (!c) return ins[11:7];
    if (ins[1:0] == 2'b00) return {2'b01, ins[4:2]};
    if (ins[1:0] == 2'b01) begin
      if (f3 == 3'b001) return 5'd1;
      if (f3 == 3'b101 || f3 == 3'b110 || f3 == 3'b111) return 5'd0;
      if (f3 == 3'b100) return {2'b01, ins[9:7]};
      return ins[11:7];
    end
    if (ins[1:0] == 2'b10 && f3 == 3'b100 && ins[12] && ins[11:7] != 5'd0 && ins[6:2] == 5'd0) return 5'd1;
    return ins[11:7];
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic [31:1] pc, input logic [1:0] br, input logic [1:0] tk);
    exp_t e;
`ifdef RVC_SUPPORT_EN
    if (!pc[1]) hq.push_back('{d[15:0], {pc[31:2], 1'b0}, br[0], tk[0]});
    hq.push_back('{d[31:16], {pc[31:2], 1'b1}, br[1], tk[1]});
    while (hq.size() > 0) begin
      if (hq[0].d[1:0] == 2'b11) begin
        if (hq.size() < 2) break;
        e = '{{hq[1].d, hq[0].d}, hq[0].pc, 1'b0, hq[0].br, hq[0].tk, 5'd0};
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else begin
        e = '{{16'h0000, hq[0].d}, hq[0].pc, 1'b1, hq[0].br, hq[0].tk, 5'd0};
        void'(hq.pop_front());
      end
      e.rd = ref_rd(e.instr, e.c);
      expq.push_back(e);
    end
`else
    e = '{d, pc, 1'b0, br[pc[1]], tk[pc[1]], d[11:7]};
    expq.push_back(e);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] d, input logic [31:1] pc, input logic [1:0] br, input logic [1:0] tk);
    fetch_valid = v; fetch_data = d; fetch_pc = pc; fetch_br = br; fetch_br_taken = tk;
  endtask

  task automatic do_flush();
    flush = 1'b1; fetch_valid = 1'b0;
    step();
    flush = 1'b0;
    expq.delete(); hq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; ready_d1 = 1'b1;
    set_fetch(1'b1, 32'h00A00093, 31'h0, 2'b00, 2'b00);
    step(); step();
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL rst_fetch_ready got=%b want=0", fetch_ready); end
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", valid_d1); end
    total++; if (instr_d1 !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", instr_d1); end
    total++; if (pc_d1 !== 31'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", pc_d1); end
    total++; if ({compressed_d1, br_d1, br_taken_d1} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {compressed_d1, br_d1, br_taken_d1}); end
    total++; if (rd_addr_d1 !== 5'd0) begin bad++; $display("FAIL rst_rd got=%0d want=0", rd_addr_d1); end
    rst = 1'b0; fetch_valid = 1'b0;
    step(); step();
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL rst_word_dropped got=%b want=0", valid_d1); end
  endtask

  task automatic test_basic();
    do_flush();
    ready_d1 = 1'b1;
    set_fetch(1'b1, 32'h00A00093, 31'h0, 2'b00, 2'b00);
    #1;
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", fetch_ready); end
    step();
    set_fetch(1'b1, 32'h00100113, 31'h2, 2'b00, 2'b00);
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL basic_latency got=%b want=0", valid_d1); end
    step();
    fetch_valid = 1'b0;
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1} !== {1'b1, 32'h00A00093, 31'h0, 1'b0, 5'd1}) begin
      bad++; $display("FAIL basic_first got=%b/%h/%h/%b/%0d want=1/00a00093/0/0/1", valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1); end
    step();
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1} !== {1'b1, 32'h00100113, 31'h2, 1'b0, 5'd2}) begin
      bad++; $display("FAIL basic_second got=%b/%h/%h/%b/%0d want=1/00100113/2/0/2", valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1); end
    step();
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b want=0", valid_d1); end
  endtask

  task automatic test_compressed();
    do_flush();
    ready_d1 = 1'b1;
`ifdef RVC_SUPPORT_EN
    set_fetch(1'b1, 32'h45014581, 31'h0, 2'b00, 2'b00); step(); fetch_valid = 1'b0; step();
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1} !== {1'b1, 32'h00004581, 31'h0, 1'b1, 5'd11}) begin
      bad++; $display("FAIL cli_x11 got=%b/%h/%h/%b/%0d want=1/00004581/0/1/11", valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1); end
    step();
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1} !== {1'b1, 32'h00004501, 31'h1, 1'b1, 5'd10}) begin
      bad++; $display("FAIL cli_x10 got=%b/%h/%h/%b/%0d want=1/00004501/1/1/10", valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1); end
    set_fetch(1'b1, 32'h00934581, 31'h0, 2'b00, 2'b00); step(); fetch_valid = 1'b0; step();
    total++; if ({valid_d1, instr_d1} !== {1'b1, 32'h00004581}) begin bad++; $display("FAIL split_cli got=%b/%h want=1/00004581", valid_d1, instr_d1); end
    step(); step();
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL split_wait got=%b want=0", valid_d1); end
    set_fetch(1'b1, 32'h000100A0, 31'h2, 2'b00, 2'b00); step(); fetch_valid = 1'b0; step();
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1} !== {1'b1, 32'h00A00093, 31'h1, 1'b0, 5'd1}) begin
      bad++; $display("FAIL split_join got=%b/%h/%h/%b/%0d want=1/00a00093/1/0/1", valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1); end
    step();
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1} !== {1'b1, 32'h00000001, 31'h3, 1'b1}) begin
      bad++; $display("FAIL split_tail got=%b/%h/%h/%b want=1/00000001/3/1", valid_d1, instr_d1, pc_d1, compressed_d1); end
`else
    set_fetch(1'b1, 32'h45014581, 31'h0, 2'b00, 2'b00); step(); fetch_valid = 1'b0; step();
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1} !== {1'b1, 32'h45014581, 31'h0, 1'b0, 5'd11}) begin
      bad++; $display("FAIL norvc_word got=%b/%h/%h/%b/%0d want=1/45014581/0/0/11", valid_d1, instr_d1, pc_d1, compressed_d1, rd_addr_d1); end
    set_fetch(1'b1, 32'h00934581, 31'h1, 2'b10, 2'b00); step(); fetch_valid = 1'b0; step();
    total++; if ({valid_d1, instr_d1, pc_d1, compressed_d1, br_d1} !== {1'b1, 32'h00934581, 31'h1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL norvc_misaligned got=%b/%h/%h/%b/%b want=1/00934581/1/0/1", valid_d1, instr_d1, pc_d1, compressed_d1, br_d1); end
`endif
  endtask

  task automatic test_stall();
    logic [31:0] w [4];
    logic [31:0] held;
    logic [31:1] held_pc;
    int si, gi, idx;
    logic filled, acc;
    w[0] = 32'h00A00093; w[1] = 32'h00100113; w[2] = 32'h00300193; w[3] = 32'h00400213;
    do_flush();
    ready_d1 = 1'b0; si = 0; filled = 1'b0;
    for (int c = 0; c < 12 && !filled; c++) begin
      idx = (si < 4) ? si : 3;
      set_fetch(si < 4, w[idx], 31'(2 * idx), 2'b00, 2'b00);
      #1;
      if (!fetch_ready && valid_d1) begin
        filled = 1'b1;
      end else begin
        acc = fetch_valid && fetch_ready;
        step();
        if (acc) si++;
      end
    end
    total++; if (filled !== 1'b1) begin bad++; $display("FAIL stall_fill got=%b want=1", filled); end
    held = instr_d1; held_pc = pc_d1;
    total++; if (held !== w[0]) begin bad++; $display("FAIL stall_head got=%h want=%h", held, w[0]); end
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if ({fetch_ready, valid_d1, instr_d1, pc_d1} !== {1'b0, 1'b1, held, held_pc}) begin
        bad++; $display("FAIL stall_hold cycle %0d got=%b/%b/%h/%h want=0/1/%h/%h", c, fetch_ready, valid_d1, instr_d1, pc_d1, held, held_pc); end
    end
    ready_d1 = 1'b1; gi = 0;
    for (int c = 0; c < 20 && gi < 4; c++) begin
      idx = (si < 4) ? si : 3;
      set_fetch(si < 4, w[idx], 31'(2 * idx), 2'b00, 2'b00);
      #1;
      if (valid_d1) begin
        total++; if ({instr_d1, pc_d1} !== {w[gi], 31'(2 * gi)}) begin
          bad++; $display("FAIL stall_order %0d got=%h/%h want=%h/%h", gi, instr_d1, pc_d1, w[gi], 31'(2 * gi)); end
        gi++;
      end
      acc = fetch_valid && fetch_ready;
      step();
      if (acc) si++;
    end
    total++; if (gi !== 4) begin bad++; $display("FAIL stall_drain got=%0d want=4", gi); end
    fetch_valid = 1'b0; ready_d1 = 1'b0;
    set_fetch(1'b1, w[3], 31'h6, 2'b00, 2'b00); step(); fetch_valid = 1'b0; step();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if ({valid_d1, instr_d1} !== {1'b0, 32'h0}) begin bad++; $display("FAIL stall_reset got=%b/%h want=0/0", valid_d1, instr_d1); end
    ready_d1 = 1'b1;
    set_fetch(1'b1, w[1], 31'h2, 2'b00, 2'b00); step(); fetch_valid = 1'b0;
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL post_reset_latency got=%b want=0", valid_d1); end
    step();
    total++; if ({valid_d1, instr_d1} !== {1'b1, w[1]}) begin bad++; $display("FAIL post_reset_issue got=%b/%h want=1/%h", valid_d1, instr_d1, w[1]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [8];
    logic [15:0] hw [16];
    int wi, gi, nexp;
    logic acc;
    exp_t e;
`ifdef RVC_SUPPORT_EN
    hw[0] = 16'h4581; hw[15] = 16'h0001;
    for (int j = 0; j < 7; j++) begin hw[1 + 2 * j] = 16'h0093; hw[2 + 2 * j] = 16'h00A0; end
    for (int k = 0; k < 8; k++) words[k] = {hw[2 * k + 1], hw[2 * k]};
    nexp = 9;
`else
    for (int k = 0; k < 8; k++) words[k] = 32'h00000013 | (32'(k) << 7);
    nexp = 8;
`endif
    do_flush();
    ready_d1 = 1'b1; wi = 0; gi = 0;
    for (int c = 0; c < 30 && gi < nexp; c++) begin
      set_fetch(wi < 8, words[(wi < 8) ? wi : 7], 31'(2 * wi), 2'b00, 2'b00);
      #1;
      if (wi < 8) begin
        total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cycle %0d got=%b want=1", c, fetch_ready); end
      end
      if (valid_d1) begin
        if (expq.size() == 0) begin
          total++; bad++; $display("FAIL b2b_extra got=%h want=none", instr_d1);
        end else begin
          e = expq.pop_front();
          total++; if ({instr_d1, pc_d1, compressed_d1, rd_addr_d1} !== {e.instr, e.pc, e.c, e.rd}) begin
            bad++; $display("FAIL b2b_payload %0d got=%h/%h/%b/%0d want=%h/%h/%b/%0d", gi, instr_d1, pc_d1, compressed_d1, rd_addr_d1, e.instr, e.pc, e.c, e.rd); end
        end
        gi++;
      end else if (gi > 0) begin
        total++; bad++; $display("FAIL b2b_bubble after %0d got=0 want=1", gi);
      end
      acc = fetch_valid && fetch_ready;
      step();
      if (acc) begin model_accept(words[wi], 31'(2 * wi), 2'b00, 2'b00); wi++; end
    end
    total++; if (gi !== nexp) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", gi, nexp); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_branch_flush();
    do_flush();
    ready_d1 = 1'b1;
`ifdef RVC_SUPPORT_EN
    set_fetch(1'b1, 32'h45014581, 31'h0, 2'b01, 2'b01); step(); fetch_valid = 1'b0; step();
    total++; if ({valid_d1, instr_d1, br_d1, br_taken_d1} !== {1'b1, 32'h00004581, 1'b1, 1'b1}) begin
      bad++; $display("FAIL taken_issue got=%b/%h/%b/%b want=1/00004581/1/1", valid_d1, instr_d1, br_d1, br_taken_d1); end
    step();
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL taken_discard got=%b/%h want=0", valid_d1, instr_d1); end
`else
    set_fetch(1'b1, 32'h00A00093, 31'h1, 2'b10, 2'b10); step();
    set_fetch(1'b1, 32'h00A00093, 31'h2, 2'b10, 2'b10); step(); fetch_valid = 1'b0;
    total++; if ({valid_d1, br_d1, br_taken_d1} !== 3'b111) begin bad++; $display("FAIL tag_hw1 got=%b want=111", {valid_d1, br_d1, br_taken_d1}); end
    step();
    total++; if ({valid_d1, br_d1, br_taken_d1} !== 3'b100) begin bad++; $display("FAIL tag_hw0 got=%b want=100", {valid_d1, br_d1, br_taken_d1}); end
`endif
    do_flush();
    set_fetch(1'b1, 32'h00A00093, 31'h0, 2'b00, 2'b00); step();
    set_fetch(1'b1, 32'h00100113, 31'h2, 2'b00, 2'b00); step();
    ready_d1 = 1'b0; flush = 1'b1;
    set_fetch(1'b1, 32'h00300193, 31'h4, 2'b00, 2'b00);
    #1;
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", fetch_ready); end
    step();
    flush = 1'b0; fetch_valid = 1'b0;
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", valid_d1); end
    ready_d1 = 1'b1;
    step(); step();
    total++; if (valid_d1 !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%b/%h want=0", valid_d1, instr_d1); end
  endtask

  task automatic test_random();
    logic fl, acc, prev_stall;
    logic [31:0] h_instr, d;
    logic [31:1] h_pc, pc;
    logic [1:0] br;
    exp_t e;
    do_flush();
    prev_stall = 1'b0; h_instr = '0; h_pc = '0;
    for (int c = 0; c < 3020; c++) begin
      if (c < 3000) begin
        fl = ($urandom_range(0, 49) == 0);
        ready_d1 = ($urandom_range(0, 3) != 0);
        d = $urandom; pc = 31'($urandom); br = 2'($urandom);
        set_fetch($urandom_range(0, 3) != 0, d, pc, br, 2'b00);
      end else begin
        fl = 1'b0; ready_d1 = 1'b1; fetch_valid = 1'b0;
      end
      flush = fl;
      #1;
      if (prev_stall) begin
        total++; if ({valid_d1, instr_d1, pc_d1} !== {1'b1, h_instr, h_pc}) begin
          bad++; $display("FAIL rand_hold cycle %0d got=%b/%h/%h want=1/%h/%h", c, valid_d1, instr_d1, pc_d1, h_instr, h_pc); end
      end
      if (!fl && valid_d1 && ready_d1) begin
        if (expq.size() == 0) begin
          total++; bad++; $display("FAIL rand_extra cycle %0d got=%h want=none", c, instr_d1);
        end else begin
          e = expq.pop_front();
          total++; if ({instr_d1, pc_d1, compressed_d1, br_d1, rd_addr_d1} !== {e.instr, e.pc, e.c, e.br, e.rd}) begin
            bad++; $display("FAIL rand_issue cycle %0d got=%h/%h/%b/%b/%0d want=%h/%h/%b/%b/%0d", c,
                            instr_d1, pc_d1, compressed_d1, br_d1, rd_addr_d1, e.instr, e.pc, e.c, e.br, e.rd); end
        end
      end
      acc = fetch_valid && fetch_ready;
      prev_stall = valid_d1 && !ready_d1 && !fl;
      h_instr = instr_d1; h_pc = pc_d1;
      step();
      if (fl) begin expq.delete(); hq.delete(); end
      else if (acc) model_accept(fetch_data, fetch_pc, fetch_br, fetch_br_taken);
    end
    flush = 1'b0;
    total++; if (expq.size() !== 0) begin bad++; $display("FAIL rand_drain got=%0d want=0 pending", expq.size()); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ready_d1 = 1'b0;
    set_fetch(1'b0, 32'h0, 31'h0, 2'b00, 2'b00);
    test_reset();
    test_basic();
    test_compressed();
    test_stall();
    test_back_to_back();
    test_branch_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
